// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-processor control unit: opcodes,
// bus select codes, enable bit positions, ALU codes and FSM/decode encodings.
package ctrl_pkg;

    localparam logic [31:0] OP_NOP    = 32'd0;
    localparam logic [31:0] OP_LDAC   = 32'd1;
    localparam logic [31:0] OP_LDIAC  = 32'd2;
    localparam logic [31:0] OP_STAC   = 32'd3;
    localparam logic [31:0] OP_MVACR  = 32'd4;
    localparam logic [31:0] OP_MVACAR = 32'd5;
    localparam logic [31:0] OP_ADD    = 32'd32;
    localparam logic [31:0] OP_SUB    = 32'd33;
    localparam logic [31:0] OP_MULT   = 32'd34;
    localparam logic [31:0] OP_LSHIFT = 32'd35;
    localparam logic [31:0] OP_INAC   = 32'd36;
    localparam logic [31:0] OP_CLAC   = 32'd37;
    localparam logic [31:0] OP_JPNZ   = 32'd40;
    localparam logic [31:0] OP_JMPZ   = 32'd41;
    localparam logic [31:0] OP_END    = 32'd63;

    localparam logic [4:0] SEL_NONE = 5'd0;
    localparam logic [4:0] SEL_PC   = 5'd1;
    localparam logic [4:0] SEL_IR   = 5'd4;
    localparam logic [4:0] SEL_AC   = 5'd5;
    localparam logic [4:0] SEL_R    = 5'd6;
    localparam logic [4:0] SEL_DM   = 5'd12;
    localparam logic [4:0] SEL_IM   = 5'd13;
    localparam logic [4:0] SEL_R1   = 5'd16;

    localparam int EN_PC  = 1;
    localparam int EN_AR  = 2;
    localparam int EN_IR  = 3;
    localparam int EN_AC  = 4;
    localparam int EN_R   = 5;
    localparam int EN_DM  = 6;
    localparam int EN_IM  = 7;
    localparam int EN_ALU = 8;
    localparam int EN_R1  = 9;

    localparam logic [2:0] ALU_PASS   = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_MULT   = 3'd3;
    localparam logic [2:0] ALU_LSHIFT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FETCH, S_DECODE, S_EXEC1, S_EXEC2, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_LDAC, CLS_LDIAC, CLS_STAC, CLS_MVACR, CLS_MVACAR,
        CLS_MVACRK, CLS_MVRKAC, CLS_ALU, CLS_INAC, CLS_CLAC,
        CLS_JPNZ, CLS_JMPZ, CLS_END
    } op_class_e;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decoder: class, GPR index (k-1), ALU op and legality.
// Rk forms are only legal for k <= NUM_GPR.
module ctrl_opdecode
    import ctrl_pkg::*;
#(
    parameter int NUM_GPR = 4,
    parameter int OPC_W   = 6
) (
    input  logic [OPC_W-1:0] opcode_i,
    output op_class_e        cls_o,
    output logic [2:0]       gpr_o,
    output logic [2:0]       alu_op_o,
    output logic             legal_o
);

    logic [31:0] op_ext;
    assign op_ext = 32'(opcode_i);

    always_comb begin
        cls_o    = CLS_NOP;
        gpr_o    = op_ext[2:0];
        alu_op_o = ALU_PASS;
        legal_o  = 1'b1;
        case (op_ext)
            OP_NOP:    cls_o = CLS_NOP;
            OP_LDAC:   cls_o = CLS_LDAC;
            OP_LDIAC:  cls_o = CLS_LDIAC;
            OP_STAC:   cls_o = CLS_STAC;
            OP_MVACR:  cls_o = CLS_MVACR;
            OP_MVACAR: cls_o = CLS_MVACAR;
            OP_ADD:    begin cls_o = CLS_ALU; alu_op_o = ALU_ADD;    end
            OP_SUB:    begin cls_o = CLS_ALU; alu_op_o = ALU_SUB;    end
            OP_MULT:   begin cls_o = CLS_ALU; alu_op_o = ALU_MULT;   end
            OP_LSHIFT: begin cls_o = CLS_ALU; alu_op_o = ALU_LSHIFT; end
            OP_INAC:   cls_o = CLS_INAC;
            OP_CLAC:   cls_o = CLS_CLAC;
            OP_JPNZ:   cls_o = CLS_JPNZ;
            OP_JMPZ:   cls_o = CLS_JMPZ;
            OP_END:    cls_o = CLS_END;
            default: begin
                // 8..15 are MVACRk, 16..23 are MVRkAC; low 3 bits hold k-1
                if (op_ext[31:3] == 29'd1 && 32'(op_ext[2:0]) < NUM_GPR)
                    cls_o = CLS_MVACRK;
                else if (op_ext[31:3] == 29'd2 && 32'(op_ext[2:0]) < NUM_GPR)
                    cls_o = CLS_MVRKAC;
                else
                    legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_seq.sv
// Control unit FSM for the accumulator processor: fetch/decode/execute
// sequencing with memory ready handshake, illegal-opcode trap and retire counter.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// START  | clear PC and AR
// FETCH  | IM -> IR, PC++ once mem_ready
// DECODE | latch opcode class, trap illegal opcodes
// EXEC1  | first (usually only) execute cycle
// EXEC2  | DM -> AC for LDAC/LDIAC
// HALT   | stopped after END or trap, waiting for start
module control_seq
    import ctrl_pkg::*;
#(
    parameter int  NUM_GPR = 4,
    parameter int  OPC_W   = 6,
    parameter int  CNT_W   = 16,
    localparam int EN_W    = 9 + NUM_GPR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPC_W-1:0] instruction,
    input  logic             z,
    input  logic             mem_ready,
    output logic [4:0]       read_en,
    output logic [EN_W-1:0]  write_en,
    output logic [EN_W-1:0]  inc_en,
    output logic [EN_W-1:0]  clr_en,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic             end_process,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [EN_W-1:0] EN_ONE = EN_W'(1);

    state_e           state_q, state_d;
    op_class_e        cls_q, cls_d;
    logic [2:0]       gpr_q, gpr_d;
    logic [2:0]       alu_q, alu_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    op_class_e  dec_cls;
    logic [2:0] dec_gpr;
    logic [2:0] dec_alu;
    logic       dec_legal;

    ctrl_opdecode #(
        .NUM_GPR (NUM_GPR),
        .OPC_W   (OPC_W)
    ) u_opdecode (
        .opcode_i (instruction),
        .cls_o    (dec_cls),
        .gpr_o    (dec_gpr),
        .alu_op_o (dec_alu),
        .legal_o  (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_NOP;
            gpr_q     <= '0;
            alu_q     <= ALU_PASS;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            gpr_q     <= gpr_d;
            alu_q     <= alu_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        gpr_d       = gpr_q;
        alu_d       = alu_q;
        illegal_d   = illegal_q;
        retire      = 1'b0;
        read_en     = SEL_NONE;
        write_en    = '0;
        inc_en      = '0;
        clr_en      = '0;
        alu_op      = ALU_PASS;
        busy        = 1'b1;
        end_process = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_START;
            end
            S_START: begin
                clr_en[EN_PC] = 1'b1;
                clr_en[EN_AR] = 1'b1;
                state_d       = S_FETCH;
            end
            S_FETCH: begin
                read_en = SEL_IM;
                if (mem_ready) begin
                    write_en[EN_IR] = 1'b1;
                    inc_en[EN_PC]   = 1'b1;
                    state_d         = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                gpr_d = dec_gpr;
                alu_d = dec_alu;
                if (dec_legal) begin
                    state_d = S_EXEC1;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC1: begin
                state_d = S_FETCH;
                retire  = 1'b1;
                case (cls_q)
                    CLS_LDAC, CLS_LDIAC: begin
                        read_en         = (cls_q == CLS_LDAC) ? SEL_AC : SEL_IR;
                        write_en[EN_AR] = 1'b1;
                        state_d         = S_EXEC2;
                        retire          = 1'b0;
                    end
                    CLS_STAC: begin
                        read_en = SEL_AC;
                        if (mem_ready) begin
                            write_en[EN_DM] = 1'b1;
                        end else begin
                            state_d = S_EXEC1;
                            retire  = 1'b0;
                        end
                    end
                    CLS_MVACR: begin
                        read_en        = SEL_AC;
                        write_en[EN_R] = 1'b1;
                    end
                    CLS_MVACAR: begin
                        read_en         = SEL_AC;
                        write_en[EN_AR] = 1'b1;
                    end
                    CLS_MVACRK: begin
                        read_en  = SEL_AC;
                        write_en = EN_ONE << (EN_R1 + 32'(gpr_q));
                    end
                    CLS_MVRKAC: begin
                        read_en         = SEL_R1 + {2'b00, gpr_q};
                        write_en[EN_AC] = 1'b1;
                    end
                    CLS_ALU: begin
                        write_en[EN_ALU] = 1'b1;
                        alu_op           = alu_q;
                    end
                    CLS_INAC: inc_en[EN_AC] = 1'b1;
                    CLS_CLAC: clr_en[EN_AC] = 1'b1;
                    CLS_JPNZ, CLS_JMPZ: begin
                        if ((cls_q == CLS_JPNZ) ? !z : z) begin
                            read_en         = SEL_IR;
                            write_en[EN_PC] = 1'b1;
                        end
                    end
                    CLS_END: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_EXEC2: begin
                read_en = SEL_DM;
                if (mem_ready) begin
                    write_en[EN_AC] = 1'b1;
                    state_d         = S_FETCH;
                    retire          = 1'b1;
                end
            end
            S_HALT: begin
                busy        = 1'b0;
                end_process = 1'b1;
                if (start) begin
                    state_d   = S_START;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (retire && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    assign illegal_op  = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq with NUM_GPR=6 and a 3-bit retire counter
// so that counter saturation is reachable in a short run.
module tb_control_seq;

    localparam int NUM_GPR = 6;
    localparam int OPC_W   = 6;
    localparam int CNT_W   = 3;
    localparam int EN_W    = 9 + NUM_GPR;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [OPC_W-1:0] instruction;
    logic             z;
    logic             mem_ready;
    logic [4:0]       read_en;
    logic [EN_W-1:0]  write_en;
    logic [EN_W-1:0]  inc_en;
    logic [EN_W-1:0]  clr_en;
    logic [2:0]       alu_op;
    logic             busy;
    logic             end_process;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int fails  = 0;

    control_seq #(
        .NUM_GPR (NUM_GPR),
        .OPC_W   (OPC_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instruction (instruction),
        .z           (z),
        .mem_ready   (mem_ready),
        .read_en     (read_en),
        .write_en    (write_en),
        .inc_en      (inc_en),
        .clr_en      (clr_en),
        .alu_op      (alu_op),
        .busy        (busy),
        .end_process (end_process),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called in FETCH at a negedge; returns at the negedge where EXEC1 (or HALT) is visible.
    task automatic fetch_decode(input logic [OPC_W-1:0] op);
        instruction = op;
        mem_ready   = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; instruction = '0; z = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({read_en, write_en, inc_en, clr_en, alu_op} !== '0) begin
            fails++;
            $display("FAIL reset_strobes: got %h/%h/%h/%h/%h want all 0", read_en, write_en, inc_en, clr_en, alu_op);
        end
        checks++;
        if ({busy, end_process, illegal_op, instr_count} !== '0) begin
            fails++;
            $display("FAIL reset_status: got busy=%b end=%b ill=%b cnt=%0d want 0", busy, end_process, illegal_op, instr_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_start_mem_wait;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({clr_en, write_en, busy} !== {15'h0006, 15'h0000, 1'b1}) begin
            fails++;
            $display("FAIL start_state: got clr=%h wr=%h busy=%b want 0006/0000/1", clr_en, write_en, busy);
        end
        mem_ready = 1'b0; instruction = 6'd0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({read_en, write_en, inc_en} !== {5'd13, 15'h0, 15'h0}) begin
                fails++;
                $display("FAIL fetch_hold%0d: got rd=%0d wr=%h inc=%h want 13/0000/0000", i, read_en, write_en, inc_en);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({read_en, write_en, inc_en} !== {5'd13, 15'h0008, 15'h0002}) begin
            fails++;
            $display("FAIL fetch_done: got rd=%0d wr=%h inc=%h want 13/0008/0002", read_en, write_en, inc_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({read_en, write_en, inc_en, clr_en, busy} !== {5'd0, 15'h0, 15'h0, 15'h0, 1'b1}) begin
            fails++;
            $display("FAIL decode_quiet: got rd=%0d wr=%h inc=%h clr=%h busy=%b want 0/0/0/0/1", read_en, write_en, inc_en, clr_en, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({read_en, write_en, inc_en, clr_en} !== '0) begin
            fails++;
            $display("FAIL nop_exec: got rd=%0d wr=%h inc=%h clr=%h want 0", read_en, write_en, inc_en, clr_en);
        end
        @(negedge clk);
    endtask

    task automatic test_gpr_sweep;
        fetch_decode(6'd13);
        #1;
        checks++;
        if ({read_en, write_en} !== {5'd5, 15'h4000}) begin
            fails++;
            $display("FAIL mvacr6: got rd=%0d wr=%h want 5/4000", read_en, write_en);
        end
        @(negedge clk);
        fetch_decode(6'd21);
        #1;
        checks++;
        if ({read_en, write_en} !== {5'd21, 15'h0010}) begin
            fails++;
            $display("FAIL mvr6ac: got rd=%0d wr=%h want 21/0010", read_en, write_en);
        end
        @(negedge clk);
    endtask

    task automatic test_branches;
        z = 1'b0;
        fetch_decode(6'd40);
        #1;
        checks++;
        if ({read_en, write_en} !== {5'd4, 15'h0002}) begin
            fails++;
            $display("FAIL jpnz_taken: got rd=%0d wr=%h want 4/0002", read_en, write_en);
        end
        @(negedge clk);
        z = 1'b1;
        fetch_decode(6'd40);
        #1;
        checks++;
        if ({read_en, write_en, inc_en, clr_en} !== '0) begin
            fails++;
            $display("FAIL jpnz_not_taken: got rd=%0d wr=%h want 0/0000", read_en, write_en);
        end
        @(negedge clk);
        z = 1'b1;
        fetch_decode(6'd41);
        #1;
        checks++;
        if ({read_en, write_en} !== {5'd4, 15'h0002}) begin
            fails++;
            $display("FAIL jmpz_taken: got rd=%0d wr=%h want 4/0002", read_en, write_en);
        end
        @(negedge clk);
        z = 1'b0;
        fetch_decode(6'd41);
        #1;
        checks++;
        if ({read_en, write_en, inc_en, clr_en} !== '0) begin
            fails++;
            $display("FAIL jmpz_not_taken: got rd=%0d wr=%h want 0/0000", read_en, write_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if (instr_count !== 3'd7) begin
            fails++;
            $display("FAIL count_seven: got %0d want 7", instr_count);
        end
        fetch_decode(6'd0);
        @(negedge clk);
        #1;
        checks++;
        if (instr_count !== 3'd7) begin
            fails++;
            $display("FAIL count_saturate: got %0d want 7", instr_count);
        end
    endtask

    task automatic test_illegal;
        fetch_decode(6'd14);
        #1;
        checks++;
        if ({illegal_op, end_process, busy} !== 3'b110) begin
            fails++;
            $display("FAIL illegal_halt: got ill=%b end=%b busy=%b want 1/1/0", illegal_op, end_process, busy);
        end
        checks++;
        if ({read_en, write_en, inc_en, clr_en, instr_count} !== {5'd0, 45'h0, 3'd7}) begin
            fails++;
            $display("FAIL illegal_quiet: got rd=%0d wr=%h cnt=%0d want 0/0000/7", read_en, write_en, instr_count);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({illegal_op, end_process, clr_en} !== {1'b0, 1'b0, 15'h0006}) begin
            fails++;
            $display("FAIL illegal_clear: got ill=%b end=%b clr=%h want 0/0/0006", illegal_op, end_process, clr_en);
        end
    endtask

    task automatic test_program;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        fetch_decode(6'd32);
        #1;
        checks++;
        if ({alu_op, write_en} !== {3'd1, 15'h0100}) begin
            fails++;
            $display("FAIL add_exec: got alu=%0d wr=%h want 1/0100", alu_op, write_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if (read_en !== 5'd13) begin
            fails++;
            $display("FAIL add_latency: got rd=%0d want 13", read_en);
        end
        fetch_decode(6'd33);
        #1;
        checks++;
        if ({alu_op, write_en} !== {3'd2, 15'h0100}) begin
            fails++;
            $display("FAIL sub_exec: got alu=%0d wr=%h want 2/0100", alu_op, write_en);
        end
        @(negedge clk);
        fetch_decode(6'd1);
        start = 1'b1;
        #1;
        checks++;
        if ({read_en, write_en} !== {5'd5, 15'h0004}) begin
            fails++;
            $display("FAIL ldac_exec1: got rd=%0d wr=%h want 5/0004", read_en, write_en);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({read_en, write_en} !== {5'd12, 15'h0010}) begin
            fails++;
            $display("FAIL ldac_exec2: got rd=%0d wr=%h want 12/0010", read_en, write_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({read_en, instr_count} !== {5'd13, 3'd3}) begin
            fails++;
            $display("FAIL ldac_latency: got rd=%0d cnt=%0d want 13/3", read_en, instr_count);
        end
        fetch_decode(6'd63);
        @(negedge clk);
        #1;
        checks++;
        if ({end_process, busy, instr_count} !== {1'b1, 1'b0, 3'd4}) begin
            fails++;
            $display("FAIL end_halt: got end=%b busy=%b cnt=%0d want 1/0/4", end_process, busy, instr_count);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({clr_en, busy, end_process} !== {15'h0006, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL restart: got clr=%h busy=%b end=%b want 0006/1/0", clr_en, busy, end_process);
        end
    endtask

    task automatic test_reset_midwait;
        @(negedge clk);
        fetch_decode(6'd1);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({read_en, write_en} !== {5'd12, 15'h0000}) begin
            fails++;
            $display("FAIL exec2_wait: got rd=%0d wr=%h want 12/0000", read_en, write_en);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({read_en, write_en, inc_en, clr_en, alu_op, busy, end_process, illegal_op, instr_count} !== '0) begin
            fails++;
            $display("FAIL midwait_reset: got rd=%0d wr=%h busy=%b cnt=%0d want all 0", read_en, write_en, busy, instr_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_stays: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_start_mem_wait();
        test_gpr_sweep();
        test_branches();
        test_illegal();
        test_program();
        test_reset_midwait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
